// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/cache requests in, latch
// enables, flushes, halt status and performance counters out.
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             stall;
   logic             flush_if;
   logic             flush_id;
   logic             flush_ex;
   logic             ihit;
   logic             dhit;
   logic             dmemREN_mem;
   logic             dmemWEN_mem;
   logic             halt_wb;
   logic             pc_en;
   logic             en_ifid;
   logic             en_idex;
   logic             en_exmem;
   logic             en_memwb;
   logic             flush_ifid;
   logic             flush_idex;
   logic             flush_exmem;
   logic             halted;
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output stall, flush_if, flush_id, flush_ex,
      output ihit, dhit, dmemREN_mem, dmemWEN_mem, halt_wb,
      input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
      input  flush_ifid, flush_idex, flush_exmem,
      input  halted, cyc_cnt, stall_cnt, flush_cnt
   );

   modport slave (
      input  stall, flush_if, flush_id, flush_ex,
      input  ihit, dhit, dmemREN_mem, dmemWEN_mem, halt_wb,
      output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
      output flush_ifid, flush_idex, flush_exmem,
      output halted, cyc_cnt, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline advance controller: latch enables/flushes, held
// flush requests across freezes, halt tracking, perf counters.
module pipe_ctrl #(
   parameter int CNT_W = 32
) (
   input logic        CLK,
   input logic        nRST,
   pipe_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN, HOLD, HALT} state_e;

   state_e           state_q, state_d;
   logic [2:0]       pend_q, pend_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] stl_q, stl_d;
   logic [CNT_W-1:0] flu_q, flu_d;

   logic       dbusy;
   logic       live;
   logic       adv;
   logic       hold_fetch;
   logic       stl_inc;
   logic       flu_inc;
   logic [2:0] req;
   logic [2:0] fx;

   // nRST gates adv so outputs drop the moment reset asserts
   always_comb begin
      dbusy = (bus.dmemREN_mem | bus.dmemWEN_mem) & ~bus.dhit;
      req   = {bus.flush_if, bus.flush_id, bus.flush_ex};
      live  = (state_q != HALT);
      adv   = nRST & bus.ihit & ~dbusy & live;
      fx    = adv ? (req | pend_q) : 3'b000;
      hold_fetch = adv & bus.stall & ~fx[2];
      stl_inc = live & (~adv | hold_fetch);
      flu_inc = |fx;
   end

   assign bus.pc_en       = adv & ~hold_fetch;
   assign bus.en_ifid     = adv & ~hold_fetch;
   assign bus.en_idex     = adv;
   assign bus.en_exmem    = adv;
   assign bus.en_memwb    = adv;
   assign bus.flush_ifid  = fx[2];
   assign bus.flush_idex  = fx[1];
   assign bus.flush_exmem = fx[0];
   assign bus.halted      = (state_q == HALT);
   assign bus.cyc_cnt     = cyc_q;
   assign bus.stall_cnt   = stl_q;
   assign bus.flush_cnt   = flu_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (adv && bus.halt_wb) state_d = HALT;
            else if (!adv)          state_d = HOLD;
         end
         HOLD: begin
            if (adv) state_d = bus.halt_wb ? HALT : RUN;
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      pend_d = pend_q;
      cyc_d  = cyc_q;
      stl_d  = stl_q;
      flu_d  = flu_q;
      if (live) begin
         pend_d = adv ? 3'b000 : (pend_q | req);
         cyc_d  = cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
         stl_d  = stl_q + {{(CNT_W-1){1'b0}}, stl_inc};
         flu_d  = flu_q + {{(CNT_W-1){1'b0}}, flu_inc};
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
         pend_q  <= 3'b000;
         cyc_q   <= '0;
         stl_q   <= '0;
         flu_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cyc_q   <= cyc_d;
         stl_q   <= stl_d;
         flu_q   <= flu_d;
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_pipe_ctrl;
   localparam int W = 32;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   pipe_ctrl_if #(.CNT_W(W)) bus ();

   pipe_ctrl #(.CNT_W(W)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // model: halted flag, remembered flush requests, counters
   bit         m_halted = 0;
   bit         m_pif = 0, m_pid = 0, m_pex = 0;
   logic [W-1:0] m_cyc = '0, m_stl = '0, m_flu = '0;

   always @(negedge CLK) begin
      bit busy, adv, fif, fid, fex, keep;
      if (!nRST) begin
         m_halted = 0;
         m_pif = 0; m_pid = 0; m_pex = 0;
         m_cyc = '0; m_stl = '0; m_flu = '0;
         adv = 0; fif = 0; fid = 0; fex = 0; keep = 0;
      end else begin
         busy = (bus.dmemREN_mem || bus.dmemWEN_mem) && !bus.dhit;
         adv  = bus.ihit && !busy && !m_halted;
         fif  = adv && (bus.flush_if || m_pif);
         fid  = adv && (bus.flush_id || m_pid);
         fex  = adv && (bus.flush_ex || m_pex);
         keep = adv && bus.stall && !fif;
      end
      chk("m_pc_en", W'(bus.pc_en), W'(adv && !keep));
      chk("m_en_ifid", W'(bus.en_ifid), W'(adv && !keep));
      chk("m_en_idex", W'(bus.en_idex), W'(adv));
      chk("m_en_exmem", W'(bus.en_exmem), W'(adv));
      chk("m_en_memwb", W'(bus.en_memwb), W'(adv));
      chk("m_flush_ifid", W'(bus.flush_ifid), W'(fif));
      chk("m_flush_idex", W'(bus.flush_idex), W'(fid));
      chk("m_flush_exmem", W'(bus.flush_exmem), W'(fex));
      chk("m_halted", W'(bus.halted), W'(m_halted));
      chk("m_cyc_cnt", bus.cyc_cnt, m_cyc);
      chk("m_stall_cnt", bus.stall_cnt, m_stl);
      chk("m_flush_cnt", bus.flush_cnt, m_flu);
      if (nRST && !m_halted) begin
         m_cyc = m_cyc + 1;
         if (!adv || keep) m_stl = m_stl + 1;
         if (fif || fid || fex) m_flu = m_flu + 1;
         if (adv) begin
            m_pif = 0; m_pid = 0; m_pex = 0;
            m_halted = bus.halt_wb;
         end else begin
            m_pif = m_pif | bus.flush_if;
            m_pid = m_pid | bus.flush_id;
            m_pex = m_pex | bus.flush_ex;
         end
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_fl(input logic fi, input logic fd,
                         input logic fe);
      bus.flush_if = fi;
      bus.flush_id = fd;
      bus.flush_ex = fe;
   endtask

   initial begin
      bus.stall = 0; set_fl(0, 0, 0);
      bus.ihit = 0; bus.dhit = 0;
      bus.dmemREN_mem = 0; bus.dmemWEN_mem = 0;
      bus.halt_wb = 0;
      cyc(); cyc();
      chk("rst_pc_en", W'(bus.pc_en), 0);
      chk("rst_cyc", bus.cyc_cnt, 0);

      // free run
      nRST = 1; bus.ihit = 1;
      #1 chk("free_pc_en", W'(bus.pc_en), 1);
      repeat (10) cyc();
      chk("free_cyc", bus.cyc_cnt, 10);
      chk("free_stall", bus.stall_cnt, 0);

      // load-use
      bus.stall = 1; bus.flush_id = 1;
      #1;
      chk("lu_pc_en", W'(bus.pc_en), 0);
      chk("lu_en_ifid", W'(bus.en_ifid), 0);
      chk("lu_flush_idex", W'(bus.flush_idex), 1);
      chk("lu_en_idex", W'(bus.en_idex), 1);
      cyc();
      bus.stall = 0; bus.flush_id = 0;
      chk("lu_stall_cnt", bus.stall_cnt, 1);
      chk("lu_flush_cnt", bus.flush_cnt, 1);

      // dcache miss
      bus.dmemREN_mem = 1; bus.dhit = 0;
      #1 chk("dm_pc_en", W'(bus.pc_en), 0);
      chk("dm_en_memwb", W'(bus.en_memwb), 0);
      repeat (3) cyc();
      bus.dhit = 1;
      #1;
      chk("dm4_pc_en", W'(bus.pc_en), 1);
      chk("dm4_en_memwb", W'(bus.en_memwb), 1);
      cyc();
      chk("dm_stall_cnt", bus.stall_cnt, 4);

      // flush during freeze
      bus.dhit = 0;
      cyc();
      set_fl(1, 1, 1);
      cyc();
      set_fl(0, 0, 0);
      cyc();
      bus.dhit = 1;
      #1;
      chk("ff_flush_ifid", W'(bus.flush_ifid), 1);
      chk("ff_flush_idex", W'(bus.flush_idex), 1);
      chk("ff_flush_exmem", W'(bus.flush_exmem), 1);
      chk("ff_pc_en", W'(bus.pc_en), 1);
      cyc();
      bus.dmemREN_mem = 0;
      #1;
      chk("ff5_flush_ifid", W'(bus.flush_ifid), 0);
      chk("ff5_flush_exmem", W'(bus.flush_exmem), 0);
      chk("ff_flush_cnt", bus.flush_cnt, 2);
      chk("ff_stall_cnt", bus.stall_cnt, 7);

      // jump beats stall
      bus.flush_if = 1; bus.stall = 1;
      #1;
      chk("js_pc_en", W'(bus.pc_en), 1);
      chk("js_en_ifid", W'(bus.en_ifid), 1);
      chk("js_flush_ifid", W'(bus.flush_ifid), 1);
      cyc();
      bus.flush_if = 0; bus.stall = 0;
      chk("js_stall_cnt", bus.stall_cnt, 7);
      chk("js_flush_cnt", bus.flush_cnt, 3);

      // halt_wb without advance is ignored
      bus.ihit = 0; bus.halt_wb = 1;
      cyc();
      bus.ihit = 1; bus.halt_wb = 0;
      #1;
      chk("ih_halted", W'(bus.halted), 0);
      chk("ih_pc_en", W'(bus.pc_en), 1);

      // halt, freeze, then reset mid-cycle
      bus.halt_wb = 1;
      cyc();
      bus.halt_wb = 0;
      chk("h_halted", W'(bus.halted), 1);
      chk("h_pc_en", W'(bus.pc_en), 0);
      chk("h_en_memwb", W'(bus.en_memwb), 0);
      repeat (3) cyc();
      chk("h_halted_stuck", W'(bus.halted), 1);
      chk("h_stall_frozen", bus.stall_cnt, 8);
      #3 nRST = 0;
      #1;
      chk("hr_halted", W'(bus.halted), 0);
      chk("hr_cyc", bus.cyc_cnt, 0);
      chk("hr_stall", bus.stall_cnt, 0);
      chk("hr_flush", bus.flush_cnt, 0);
      chk("hr_pc_en", W'(bus.pc_en), 0);
      cyc(); cyc();
      nRST = 1;
      #1 chk("post_pc_en", W'(bus.pc_en), 1);
      cyc(); cyc();
      chk("post_cyc", bus.cyc_cnt, 2);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end
endmodule
